// File: rtl/shift_counter_gen_pkg.sv
// shift_counter_pkg: mode/direction encodings and the position-to-pattern decode shared by the shift counter
package shift_counter_pkg;
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  function automatic logic [31:0] decode(input logic mode, input logic [5:0] p, input int w);
    logic [32:0] m, r;
    m = (33'd1 << w) - 33'd1;
    r = mode == MODE_RING ? 33'd1 << p :
        int'(p) <= w ? (33'd1 << p) - 33'd1 : ~((33'd1 << (int'(p) - w)) - 33'd1);
    decode = 32'(r & m);
  endfunction
endpackage

// File: rtl/shift_counter_gen_if.sv
// shift_counter_gen_if: control inputs and counter outputs of shift_counter_gen
interface shift_counter_gen_if #(parameter int WIDTH = 8);
  localparam int PW = $clog2(2 * WIDTH);
  logic en, dir, mode, load;
  logic [PW-1:0] load_pos;
  logic [WIDTH-1:0] out;
  logic [PW-1:0] pos;
  logic wrap, err;
  modport master(output en, dir, mode, load, load_pos, input out, pos, wrap, err);
  modport slave(input en, dir, mode, load, load_pos, output out, pos, wrap, err);
endinterface

// File: rtl/shift_counter_gen_chk.sv
// shift_counter_chk: decodes a position into its expected pattern and flags a register that disagrees
module shift_counter_chk import shift_counter_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int PW = $clog2(2 * WIDTH)
) (
  input  logic             mode,
  input  logic [PW-1:0]    pos,
  input  logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] dec,
  output logic             bad
);
  // pattern for pos in the given mode, and whether out matches it
  always_comb begin
    dec = WIDTH'(decode(mode, 6'(pos), WIDTH));
    bad = out != dec;
  end
endmodule

// File: rtl/shift_counter_gen.sv
// shift_counter_gen: ring/Johnson shift counter with position tracking; SHIFT_COUNTER_SELF_CORRECT_EN adds a self-correcting checker
module shift_counter_gen import shift_counter_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  shift_counter_gen_if.slave bus
);
  localparam int PW = $clog2(2 * WIDTH);
  logic [WIDTH-1:0] out_q, ld_dec, step_out, start_out;
  logic [PW-1:0] pos_q, pos_nx;
  logic mode_q, wrap_q, err_q, ld_ok, ld_unused;
  int per;
  shift_counter_chk #(.WIDTH(WIDTH)) u_ld (.mode(mode_q), .pos(bus.load_pos), .out(out_q), .dec(ld_dec), .bad(ld_unused));
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
  logic [WIDTH-1:0] fix_dec;
  logic fix;
  shift_counter_chk #(.WIDTH(WIDTH)) u_fix (.mode(mode_q), .pos(pos_q), .out(out_q), .dec(fix_dec), .bad(fix));
`endif
  // period, load legality, next step position and pattern
  always_comb begin
    per = mode_q == MODE_JOHNSON ? 2 * WIDTH : WIDTH;
    ld_ok = int'(bus.load_pos) < per;
    pos_nx = bus.dir == DIR_RIGHT ? (pos_q == '0 ? PW'(per - 1) : pos_q - 1'b1)
                                  : (int'(pos_q) == per - 1 ? '0 : pos_q + 1'b1);
    step_out = bus.dir == DIR_RIGHT ? {mode_q ^ out_q[0], out_q[WIDTH-1:1]}
                                    : {out_q[WIDTH-2:0], mode_q ^ out_q[WIDTH-1]};
    start_out = bus.mode == MODE_RING ? WIDTH'(1) : '0;
  end
  // reset > mode change > correction > load > step > hold
  always_ff @(posedge clk)
    if (!reset || bus.mode != mode_q) begin
      mode_q <= bus.mode;
      out_q <= start_out;
      pos_q <= '0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    else if (fix) begin
      out_q <= fix_dec;
      wrap_q <= 1'b0;
      err_q <= 1'b1;
    end
`endif
    else if (bus.load) begin
      wrap_q <= 1'b0;
      err_q <= !ld_ok;
      if (ld_ok) begin
        pos_q <= bus.load_pos;
        out_q <= ld_dec;
      end
    end else if (bus.en) begin
      out_q <= step_out;
      pos_q <= pos_nx;
      wrap_q <= pos_nx == '0;
      err_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end
  assign bus.out = out_q;
  assign bus.pos = pos_q;
  assign bus.wrap = wrap_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_shift_counter_gen.sv
// tb_shift_counter_gen: table-driven directed check of shift_counter_gen at WIDTH=8
module tb_shift_counter_gen;
  typedef struct {
    logic r, en, dir, mode, load;
    logic [3:0] lp;
    logic [7:0] eo;
    logic [3:0] ep;
    logic ew, ee;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n = 0;
  int fails = 0;
  vec_t tbl[$];
  shift_counter_gen_if #(.WIDTH(8)) bus();
  shift_counter_gen #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic r, en, dir, mode, load, input logic [3:0] lp, input logic [7:0] eo, input logic [3:0] ep, input logic ew, ee);
    vec_t v;
    v = '{r, en, dir, mode, load, lp, eo, ep, ew, ee};
    tbl.push_back(v);
  endtask
  task automatic check(input string nm, input logic [31:0] a, e);
    n++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic drive(input logic r, en, dir, mode, load, input logic [3:0] lp);
    reset = r;
    bus.en = en;
    bus.dir = dir;
    bus.mode = mode;
    bus.load = load;
    bus.load_pos = lp;
  endtask
  task automatic check_all(input string nm, input logic [7:0] eo, input logic [3:0] ep, input logic ew, ee);
    check({nm, ".out"}, 32'(bus.out), 32'(eo));
    check({nm, ".pos"}, 32'(bus.pos), 32'(ep));
    check({nm, ".wrap"}, 32'(bus.wrap), 32'(ew));
    check({nm, ".err"}, 32'(bus.err), 32'(ee));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] ro [8];
    logic [7:0] jo [16];
    ro = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    jo = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    add(0, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 0, 0, 0, ro[i], 4'((i + 1) % 8), i == 7, 0);
    add(1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 0, 1, 0, 0, jo[i], 4'((i + 1) % 16), i == 15, 0);
    add(1, 1, 1, 1, 0, 0, 8'h80, 15, 0, 0);
    add(1, 1, 1, 1, 0, 0, 8'hC0, 14, 0, 0);
    add(1, 0, 0, 1, 1, 11, 8'hF8, 11, 0, 0);
    add(1, 1, 0, 1, 1, 15, 8'h80, 15, 0, 0);
    add(1, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8, 8'h01, 0, 0, 1);
    add(1, 1, 0, 0, 1, 9, 8'h01, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0);
    add(1, 0, 0, 0, 1, 4, 8'h10, 4, 0, 0);
    add(1, 1, 1, 0, 0, 0, 8'h08, 3, 0, 0);
    add(1, 1, 1, 0, 0, 0, 8'h04, 2, 0, 0);
    add(1, 1, 1, 0, 0, 0, 8'h02, 1, 0, 0);
    add(1, 1, 1, 0, 0, 0, 8'h01, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 8'h80, 7, 0, 0);
    add(1, 0, 0, 0, 1, 4, 8'h10, 4, 0, 0);
    add(1, 1, 0, 1, 1, 2, 8'h00, 0, 0, 0);
    add(1, 0, 0, 1, 1, 5, 8'h1F, 5, 0, 0);
    add(0, 1, 0, 1, 1, 3, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3, 8'h01, 0, 0, 0);
    add(1, 1, 0, 0, 1, 7, 8'h80, 7, 0, 0);
    add(1, 1, 0, 0, 0, 0, 8'h01, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 8'h01, 0, 0, 0);
    add(1, 0, 0, 0, 1, 2, 8'h04, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].load, tbl[i].lp);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), tbl[i].eo, tbl[i].ep, tbl[i].ew, tbl[i].ee);
    end
    @(negedge clk);
    force dut.out_q = 8'h24;
    #1;
    release dut.out_q;
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    check_all("corrupt_step", 8'h04, 2, 0, 1);
`else
    check_all("corrupt_step", 8'h48, 3, 0, 0);
`endif
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    check_all("corrupt_after", 8'h04, 2, 0, 0);
`else
    check_all("corrupt_after", 8'h48, 3, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
- Parametrised successor to the fixed 8-bit ring counter.
- One WIDTH-bit shift register runs as a ring counter (one-hot, period WIDTH) or a Johnson counter (twisted ring, period 2*WIDTH).
- Adds run-time mode select, up/down direction, count enable, position load and a wrap pulse.
- A parallel position counter tracks the shift state. It feeds the optional self-correction checker and drives the pos output.
- Used as a sequencer/phase generator in the lab datapath designs.

Parameters:
- WIDTH, 8, shift register width; legal range 2..32.
- PW, $clog2(2*WIDTH), width of the position index (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
- en  input  1  advance one step on this edge.
- dir  input  1  0 = shift left (toward MSB), 1 = shift right.
- mode  input  1  0 = RING, 1 = JOHNSON.
- load  input  1  load position load_pos on this edge.
- load_pos  input  PW  position to load.
- out  output  WIDTH  counter state (registered).
- pos  output  PW  current position index (registered).
- wrap  output  1  one-cycle pulse on return to position 0 by stepping.
- err  output  1  one-cycle pulse on illegal state or rejected load.

Behaviour:
- Period P = WIDTH (RING) or 2*WIDTH (JOHNSON). mode_q is a registered copy of mode.
- Priority on each rising edge: reset low > mode != mode_q > load > en > hold.
- Reset (reset==0):
  - out = 1 if mode==RING, else 0.
  - pos = 0, wrap = 0, err = 0, mode_q = mode.
- Mode change (mode != mode_q):
  - mode_q updates to mode.
  - out goes to the start state of the new mode: RING 1, JOHNSON 0.
  - pos = 0, wrap = 0. en and load are ignored this cycle.
- Load with load_pos < P: pos = load_pos, out = decode(load_pos).
- Load with load_pos >= P: out and pos hold; err pulses for 1 cycle.
- decode(p):
  - RING: 1<<p.
  - JOHNSON, p <= WIDTH: (1<<p)-1.
  - JOHNSON, p > WIDTH: ~((1<<(p-WIDTH))-1), masked to WIDTH bits.
- Step (en=1), RING:
  - dir=0: out = {out[W-2:0], out[W-1]}, pos = (pos+1) mod P.
  - dir=1: rotate right, pos = (pos-1) mod P.
- Step (en=1), JOHNSON:
  - dir=0: out = {out[W-2:0], ~out[W-1]}, pos+1 mod P.
  - dir=1: out = {~out[0], out[W-1:1]}, pos-1 mod P.
- Wrap pulse:
  - wrap = 1 for exactly the cycle after a step whose next pos is 0, in either direction.
  - wrap is never asserted by reset, load or mode change.
- Latency: out, pos and wrap update one clock after the qualifying edge. There are no combinational input-to-output paths.
- en=0 and load=0: all state holds, wrap = 0.
- Reset mid-count overrides load and en in the same cycle.

Optional Feature:
- Macro: SHIFT_COUNTER_SELF_CORRECT_EN.
- Defined:
  - Each cycle a checker compares out against decode(pos).
  - On mismatch (corrupted register), out is forced to decode(pos) on the next edge and err pulses for 1 cycle.
  - Correction takes priority over en and load but not over reset or mode change.
- Not defined:
  - No checker is present.
  - err reports only rejected loads.
  - A corrupted out keeps shifting with its corrupted pattern.

Decomposition:
- Package shift_counter_pkg:
  - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1.
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
  - A decode function parametrised by width.
- Sub-module shift_counter_chk: combinational decode(pos) plus mismatch compare. It is instantiated by both the load path and the self-correct path.

Test Plan (WIDTH=8):
- Reset low 2 cycles with mode=0, then en=1, dir=0 for 8 cycles -> out 01,02,04,...,80,01; wrap high only in the cycle out returns to 01; pos 0..7,0.
- mode=1, en=1, dir=0 for 16 cycles -> out 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; wrap once at pos 0.
- JOHNSON at pos=0, dir=1 single step -> out=80, pos=15, no wrap; next step -> out=C0, pos=14.
- load=1, load_pos=11 in JOHNSON -> out=F8, pos=11. load_pos=9 in RING -> no change, err pulse. Load and en together -> load wins.
- Toggle mode mid-count (RING, out=10) -> next cycle out=00, pos=0, wrap=0. Reset asserted alongside load -> out per reset rule.
- With SHIFT_COUNTER_SELF_CORRECT_EN defined, force out=0x24 in RING with pos=2 -> next cycle out=04 and err=1 for one cycle. Without the macro, the forced value rotates to 0x48.
